bch15_decode_sequencer: RTL and testbench
=========================================

Name: bch15_decode_sequencer

Overview:
Multi-cycle, handshaked decoder controller for the BCH(15,7,t=2) code over GF(16) (primitive poly x^4+x+1, generator 9'b111010001). It accepts one 15-bit received word and sequences three phases:
- serial syndrome computation
- error-locator solve
- serial Chien search

It returns the corrected 7-bit message with status. It replaces the fully combinational correction path where area matters, trading latency for one shared GF multiplier per phase.

Parameters:
SKIP_ZERO_SYND, 1, when 1 a zero syndrome (S1==0 && S3==0) bypasses Chien (16-cycle latency); when 0 Chien always runs (fixed 31-cycle latency)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  received word valid
in_ready  out  1  sequencer can accept a word (high only in IDLE)
in_code  in  15  received word; bit i = coefficient of x^i; [14:8] message, [7:0] parity
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
out_msg  out  7  corrected message (raw in_code[14:8] if uncorrectable)
out_err_cnt  out  2  number of bits corrected (0, 1, 2)
out_uncorr  out  1  uncorrectable pattern detected
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE; in_ready=1, busy=0.
  - out_valid=0, out_msg=0, out_err_cnt=0, out_uncorr=0.
  - All internal registers (S1, S3, sigma1, sigma2, counters, working word) = 0.
- States: IDLE, SYND, LOCATE, CHIEN, DONE.
- IDLE:
  - On in_valid&&in_ready, latch in_code into the working word W.
  - Clear S1 and S3; set bit counter cnt=14; go to SYND.
- SYND, 15 cycles, cnt 14 down to 0, Horner form:
  - S1 <= S1*alpha ^ W[cnt]
  - S3 <= S3*alpha^3 ^ W[cnt]
  - At cnt==0, go to LOCATE.
- LOCATE, 1 cycle; compute c = S3 ^ S1^3, then branch:
  - S1==0 && S3==0: no error. err_cnt=0; go to DONE if SKIP_ZERO_SYND, else CHIEN with sigma1=sigma2=0.
  - S1==0 && S3!=0: set uncorr=1; go to DONE; W is unmodified.
  - S1!=0 && c==0: single error. sigma1=S1, sigma2=0, expected degree 1; go to CHIEN.
  - Otherwise: sigma1=S1, sigma2=c*inv(S1), expected degree 2; go to CHIEN.
- CHIEN, 15 cycles, i=0..14:
  - Initialise t1=sigma1, t2=sigma2.
  - Each cycle, if 1^t1^t2==0: flip W[i] and increment root count (saturating at 3).
  - Then update t1 <= t1*alpha^-1 (=alpha^14) and t2 <= t2*alpha^-2 (=alpha^13).
  - After i==14, go to DONE.
  - If root count != expected degree: set uncorr=1, restore the message from the latched raw copy, err_cnt=0.
  - Otherwise err_cnt = root count.
- DONE:
  - out_valid=1; outputs registered and stable.
  - out_msg=W[14:8].
  - On out_valid&&out_ready, go to IDLE.
  - in_ready stays 0; there is no same-cycle accept/return overlap.
- Latency, counted in clock edges from the input-handshake edge to out_valid visible:
  - 16 for the bypass path and for the S1==0/S3!=0 uncorrectable path.
  - 31 otherwise.
  - The next word can be accepted no earlier than the cycle after the output handshake.
- Backpressure: out_ready low holds DONE indefinitely; no output field may change.
- in_code and in_valid are ignored outside IDLE.
- rst_n low mid-operation: immediate return to reset values; the in-flight word is discarded with no output.
- GF arithmetic:
  - Multiplication is polynomial-basis mod x^4+x+1; constant multiplies are pure XOR networks.
  - inv() is a 16-entry lookup with inv(0)=0; that entry is unreachable because S1!=0 is guaranteed on that path.
  - All field values are 4 bits; no truncation issues.

Decomposition:
- Package bch15_pkg holds:
  - GF16_PRIM=5'b10011 and BCH15_GEN=9'b111010001.
  - Functions gf16_mul(a,b), gf16_inv(a), gf16_cube(a).
  - The state enum typedef, state_t {IDLE,SYND,LOCATE,CHIEN,DONE}.
- One sub-module is natural: bch15_chien_step. It is combinational; it takes t1 and t2 and returns the root flag plus next t1 and t2. It is reusable by a future parallel-Chien variant.

Test Plan:
- Valid codeword in_code=15'h01D1 -> out_msg=7'h01, err_cnt=0, uncorr=0, out_valid 16 edges after accept (31 with SKIP_ZERO_SYND=0).
- Single error 15'h11D1 (bit 12 flipped) -> out_msg=7'h01, err_cnt=1, uncorr=0, latency 31.
- Double error 15'h05D9 (bits 3 and 10 flipped) -> out_msg=7'h01, err_cnt=2, uncorr=0.
- Three-error pattern 15'h0013 (bits 0,1,4; S1=0, S3=6) -> uncorr=1, out_msg=7'h00 (raw), err_cnt=0, latency 16.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0; one out_ready pulse -> IDLE, in_ready=1 next cycle; a back-to-back second word is accepted.
- Reset mid-CHIEN: assert rst_n=0 at edge 20 of a 2-error word -> out_valid=0, in_ready=1 immediately; next word 15'h01D1 decodes correctly.

Source files
------------

// File: rtl/bch15_pkg.sv
// Shared GF(16) arithmetic and sequencer state type for the BCH(15,7,t=2) decoder.
package bch15_pkg;

  localparam logic [4:0] GF16_PRIM = 5'b10011;
  localparam logic [8:0] BCH15_GEN = 9'b111010001;

  typedef enum logic [2:0] {IDLE, SYND, LOCATE, CHIEN, DONE} state_t;

  // Polynomial-basis multiply; with a constant operand this collapses to XORs.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? GF16_PRIM[3:0] : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] r;
    unique case (a)
      4'h0: r = 4'h0;
      4'h1: r = 4'h1;
      4'h2: r = 4'h9;
      4'h3: r = 4'he;
      4'h4: r = 4'hd;
      4'h5: r = 4'hb;
      4'h6: r = 4'h7;
      4'h7: r = 4'h6;
      4'h8: r = 4'hf;
      4'h9: r = 4'h2;
      4'ha: r = 4'hc;
      4'hb: r = 4'h5;
      4'hc: r = 4'ha;
      4'hd: r = 4'h4;
      4'he: r = 4'h3;
      default: r = 4'h8;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] gf16_cube(input logic [3:0] a);
    return gf16_mul(gf16_mul(a, a), a);
  endfunction

endpackage

// File: rtl/bch15_decode_sequencer_if.sv
// Word-in / result-out handshake bundle of the BCH(15,7) decode sequencer.
interface bch15_decode_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_msg;
  logic [1:0]  out_err_cnt;
  logic        out_uncorr;
  logic        busy;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_msg, out_err_cnt, out_uncorr, busy
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_msg, out_err_cnt, out_uncorr, busy
  );
endinterface

// File: rtl/bch15_chien_step.sv
// One Chien evaluation: root flag for sigma at the current point and the terms for the next one.
module bch15_chien_step
  import bch15_pkg::*;
(
  input  logic [3:0] t1_i,
  input  logic [3:0] t2_i,
  output logic       root_o,
  output logic [3:0] t1_next_o,
  output logic [3:0] t2_next_o
);

  assign root_o    = ((4'h1 ^ t1_i ^ t2_i) == 4'h0);
  // alpha^-1 = alpha^14 = 4'h9, alpha^-2 = alpha^13 = 4'hd
  assign t1_next_o = gf16_mul(t1_i, 4'h9);
  assign t2_next_o = gf16_mul(t2_i, 4'hd);

endmodule

// File: rtl/bch15_decode_sequencer.sv
// Serial BCH(15,7,t=2) decoder: Horner syndromes, closed-form locator, serial Chien search.
module bch15_decode_sequencer
  import bch15_pkg::*;
#(
  parameter bit SKIP_ZERO_SYND = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bch15_decode_sequencer_if.slave   bus
);

  state_t      state_q, state_d;
  logic [14:0] w_q, w_d, w_n;
  logic [6:0]  raw_q, raw_d;
  logic [3:0]  s1_q, s1_d, s3_q, s3_d;
  logic [3:0]  t1_q, t1_d, t2_q, t2_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  deg_q, deg_d, rc_q, rc_d, rc_n;
  logic        out_valid_q, out_valid_d, out_uncorr_q, out_uncorr_d;
  logic [6:0]  out_msg_q, out_msg_d;
  logic [1:0]  out_err_q, out_err_d;
  logic [3:0]  c, t1_next, t2_next;
  logic        root;

  bch15_chien_step u_chien_step (
    .t1_i      (t1_q),
    .t2_i      (t2_q),
    .root_o    (root),
    .t1_next_o (t1_next),
    .t2_next_o (t2_next)
  );

  assign c = s3_q ^ gf16_cube(s1_q);

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    raw_d        = raw_q;
    s1_d         = s1_q;
    s3_d         = s3_q;
    t1_d         = t1_q;
    t2_d         = t2_q;
    cnt_d        = cnt_q;
    deg_d        = deg_q;
    rc_d         = rc_q;
    out_valid_d  = out_valid_q;
    out_msg_d    = out_msg_q;
    out_err_d    = out_err_q;
    out_uncorr_d = out_uncorr_q;
    w_n          = w_q;
    rc_n         = rc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          w_d     = bus.in_code;
          raw_d   = bus.in_code[14:8];
          s1_d    = 4'h0;
          s3_d    = 4'h0;
          cnt_d   = 4'd14;
          state_d = SYND;
        end
      end
      SYND: begin
        s1_d  = gf16_mul(s1_q, 4'h2) ^ {3'b000, w_q[cnt_q]};
        s3_d  = gf16_mul(s3_q, 4'h8) ^ {3'b000, w_q[cnt_q]};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = LOCATE;
      end
      LOCATE: begin
        cnt_d = 4'd0;
        rc_d  = 2'd0;
        t1_d  = s1_q;
        t2_d  = 4'h0;
        if (s1_q == 4'h0) begin
          deg_d = 2'd0;
          t1_d  = 4'h0;
          // S1==0 with S3!=0 cannot be one or two errors
          if (s3_q != 4'h0 || SKIP_ZERO_SYND) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            out_msg_d    = w_q[14:8];
            out_err_d    = 2'd0;
            out_uncorr_d = (s3_q != 4'h0);
          end else begin
            state_d = CHIEN;
          end
        end else if (c == 4'h0) begin
          deg_d   = 2'd1;
          state_d = CHIEN;
        end else begin
          deg_d   = 2'd2;
          t2_d    = gf16_mul(c, gf16_inv(s1_q));
          state_d = CHIEN;
        end
      end
      CHIEN: begin
        if (root) begin
          w_n[cnt_q] = ~w_q[cnt_q];
          rc_n       = (rc_q == 2'd3) ? 2'd3 : rc_q + 2'd1;
        end
        w_d   = w_n;
        rc_d  = rc_n;
        t1_d  = t1_next;
        t2_d  = t2_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd14) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (rc_n != deg_q) begin
            out_msg_d    = raw_q;
            out_err_d    = 2'd0;
            out_uncorr_d = 1'b1;
          end else begin
            out_msg_d    = w_n[14:8];
            out_err_d    = rc_n;
            out_uncorr_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      w_q          <= '0;
      raw_q        <= '0;
      s1_q         <= '0;
      s3_q         <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      cnt_q        <= '0;
      deg_q        <= '0;
      rc_q         <= '0;
      out_valid_q  <= 1'b0;
      out_msg_q    <= '0;
      out_err_q    <= '0;
      out_uncorr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      raw_q        <= raw_d;
      s1_q         <= s1_d;
      s3_q         <= s3_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      cnt_q        <= cnt_d;
      deg_q        <= deg_d;
      rc_q         <= rc_d;
      out_valid_q  <= out_valid_d;
      out_msg_q    <= out_msg_d;
      out_err_q    <= out_err_d;
      out_uncorr_q <= out_uncorr_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_msg     = out_msg_q;
  assign bus.out_err_cnt = out_err_q;
  assign bus.out_uncorr  = out_uncorr_q;

endmodule

// File: tb/tb_bch15_decode_sequencer.sv
// Directed bench: bypass (SKIP_ZERO_SYND=1) and fixed-latency (=0) decoders side by side.
module tb_bch15_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [14:0] in_code = '0;
  logic        out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bch15_decode_sequencer_if bus0 ();
  bch15_decode_sequencer_if bus1 ();

  assign bus0.in_valid  = in_valid & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus0.in_code   = in_code;
  assign bus1.in_code   = in_code;
  assign bus0.out_ready = out_ready & ~sel;
  assign bus1.out_ready = out_ready & sel;

  logic       m_in_ready, m_out_valid, m_uncorr, m_busy;
  logic [6:0] m_msg;
  logic [1:0] m_err;

  assign m_in_ready  = sel ? bus1.in_ready    : bus0.in_ready;
  assign m_out_valid = sel ? bus1.out_valid   : bus0.out_valid;
  assign m_msg       = sel ? bus1.out_msg     : bus0.out_msg;
  assign m_err       = sel ? bus1.out_err_cnt : bus0.out_err_cnt;
  assign m_uncorr    = sel ? bus1.out_uncorr  : bus0.out_uncorr;
  assign m_busy      = sel ? bus1.busy        : bus0.busy;

  bch15_decode_sequencer #(.SKIP_ZERO_SYND(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  bch15_decode_sequencer #(.SKIP_ZERO_SYND(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  typedef struct {
    logic [14:0] code;
    logic        sel;
    logic [6:0]  msg;
    logic [1:0]  err;
    logic        unc;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present a word, then count edges from the accept edge until out_valid shows (-1 on timeout).
  task automatic send_and_wait(input logic [14:0] code, input logic s, output int lat);
    sel = s;
    @(negedge clk);
    check("accept_ready", int'(m_in_ready), 1);
    in_code  = code;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (m_out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send_and_wait(v.code, v.sel, lat);
    check($sformatf("lat_%h_s%0d", v.code, v.sel), lat, v.lat);
    check($sformatf("msg_%h_s%0d", v.code, v.sel), int'(m_msg), int'(v.msg));
    check($sformatf("err_%h_s%0d", v.code, v.sel), int'(m_err), int'(v.err));
    check($sformatf("unc_%h_s%0d", v.code, v.sel), int'(m_uncorr), int'(v.unc));
    ack();
  endtask

  initial begin
    int lat;
    int unstable;
    logic [6:0] bp_msg;
    logic [1:0] bp_err;
    logic       bp_unc;

    vecs[0] = '{15'h01D1, 1'b0, 7'h01, 2'd0, 1'b0, 16};
    vecs[1] = '{15'h11D1, 1'b0, 7'h01, 2'd1, 1'b0, 31};
    vecs[2] = '{15'h05D9, 1'b0, 7'h01, 2'd2, 1'b0, 31};
    vecs[3] = '{15'h0013, 1'b0, 7'h00, 2'd0, 1'b1, 16};
    vecs[4] = '{15'h01D1, 1'b1, 7'h01, 2'd0, 1'b0, 31};
    vecs[5] = '{15'h0000, 1'b0, 7'h00, 2'd0, 1'b0, 16};
    vecs[6] = '{15'h01D0, 1'b0, 7'h01, 2'd1, 1'b0, 31};
    vecs[7] = '{15'h4000, 1'b0, 7'h00, 2'd1, 1'b0, 31};
    vecs[8] = '{15'h05D9, 1'b1, 7'h01, 2'd2, 1'b0, 31};
    vecs[9] = '{15'h0013, 1'b1, 7'h00, 2'd0, 1'b1, 16};

    #12;
    check("rst_in_ready", int'(m_in_ready), 1);
    check("rst_busy", int'(m_busy), 0);
    check("rst_out_valid", int'(m_out_valid), 0);
    check("rst_msg", int'(m_msg), 0);
    check("rst_err", int'(m_err), 0);
    check("rst_unc", int'(m_uncorr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: result must hold while out_ready stays low.
    send_and_wait(15'h11D1, 1'b0, lat);
    check("bp_lat", lat, 31);
    bp_msg = m_msg;
    bp_err = m_err;
    bp_unc = m_uncorr;
    check("bp_msg", int'(bp_msg), 1);
    check("bp_err", int'(bp_err), 1);
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (!m_out_valid || m_in_ready || m_msg != bp_msg || m_err != bp_err || m_uncorr != bp_unc)
        unstable++;
    end
    check("bp_unstable_cycles", unstable, 0);
    ack();
    check("bp_in_ready_after_ack", int'(m_in_ready), 1);
    check("bp_out_valid_after_ack", int'(m_out_valid), 0);
    run_vec(vecs[0]);

    // Reset 20 edges into a two-error word: discarded, then a clean decode.
    sel = 1'b0;
    @(negedge clk);
    in_code  = 15'h05D9;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", int'(m_busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(m_out_valid), 0);
    check("mid_rst_in_ready", int'(m_in_ready), 1);
    check("mid_rst_busy", int'(m_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (m_out_valid) check("mid_rst_spurious_valid", int'(m_out_valid), 0);
    end
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
